// File: rtl/mel_fbank_acc.sv
// Fixed-point mel filterbank accumulator: per filter, MACs a sparse band of power bins with weights.
// Optional MEL_ACC_SAT_EN: saturate the accumulator to all-ones on overflow instead of wrapping.
module mel_fbank_acc #(
    parameter int DATA_WIDTH      = 32,
    parameter int COEF_WIDTH      = 16,
    parameter int ACC_WIDTH       = 48,
    parameter int BIN_ADDR_WIDTH  = 12,
    parameter int MEL_WIDTH       = 6,
    parameter int COEF_ADDR_WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MEL_WIDTH-1:0]       mel_num,
    input  logic [BIN_ADDR_WIDTH-1:0]  fft_num,
    output logic [MEL_WIDTH-1:0]       band_addr,
    input  logic [BIN_ADDR_WIDTH-1:0]  band_start_in,
    input  logic [BIN_ADDR_WIDTH-1:0]  band_len_in,
    output logic [BIN_ADDR_WIDTH-1:0]  bin_read_addr,
    input  logic [DATA_WIDTH-1:0]      bin_data_in,
    output logic [COEF_ADDR_WIDTH-1:0] coef_read_addr,
    input  logic [COEF_WIDTH-1:0]      coef_in,
    output logic [ACC_WIDTH-1:0]       mel_data_out,
    output logic [MEL_WIDTH-1:0]       mel_write_addr,
    output logic                       write_mel_en,
    output logic                       sat_flag,
    output logic                       busy,
    output logic                       done
);

    localparam int PROD_W = DATA_WIDTH + 1;
    localparam int FULL_W = DATA_WIDTH + COEF_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]                 state;
    logic [MEL_WIDTH-1:0]       mel_num_r;
    logic [BIN_ADDR_WIDTH-1:0]  fft_num_r;
    logic [MEL_WIDTH-1:0]       mel_idx;
    logic [COEF_ADDR_WIDTH-1:0] coef_base;
    logic [BIN_ADDR_WIDTH-1:0]  len_r;
    logic [BIN_ADDR_WIDTH-1:0]  eff_len_r;
    logic [BIN_ADDR_WIDTH-1:0]  k_cnt;
    logic                       drain_cnt;
    logic                       vld_p0;
    logic                       vld_p1;
    logic [PROD_W-1:0]          prod_p1;
    logic [ACC_WIDTH-1:0]       acc;
    logic [ACC_WIDTH-1:0]       acc_next;
    logic [BIN_ADDR_WIDTH-1:0]  half_bins;
    logic [BIN_ADDR_WIDTH-1:0]  avail;
    logic [BIN_ADDR_WIDTH-1:0]  eff_len;
    logic                       drain_last;

    function automatic logic [PROD_W-1:0] scale_prod(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [COEF_WIDTH-1:0] c);
        logic [FULL_W-1:0] full;
        full = FULL_W'(d) * FULL_W'(c);
        return PROD_W'(full >> (COEF_WIDTH - 1));
    endfunction

`ifdef MEL_ACC_SAT_EN
    localparam int ACC_X = ACC_WIDTH + 1;

    logic             sat_r;
    logic             sat_next;
    logic [ACC_X-1:0] add_res;

    // Once saturated, the filter sticks at all-ones until the next band is fetched.
    function automatic logic [ACC_X-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [PROD_W-1:0]    p,
                                                 input logic                 s);
        logic [ACC_X-1:0] sum;
        sum = {1'b0, a} + ACC_X'(p);
        if (s || sum[ACC_WIDTH])
            return {1'b1, {ACC_WIDTH{1'b1}}};
        return {1'b0, sum[ACC_WIDTH-1:0]};
    endfunction

    always_comb begin
        add_res  = acc_add(acc, prod_p1, sat_r);
        sat_next = sat_r;
        acc_next = acc;
        if (vld_p1) begin
            sat_next = add_res[ACC_WIDTH];
            acc_next = add_res[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r    <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            sat_r <= (state == S_FETCH) ? 1'b0 : sat_next;
            if (state == S_FETCH)
                sat_flag <= 1'b0;
            else if (drain_last)
                sat_flag <= sat_next;
        end
    end
`else
    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [PROD_W-1:0]    p);
        return a + ACC_WIDTH'(p);
    endfunction

    always_comb begin
        acc_next = acc;
        if (vld_p1)
            acc_next = acc_add(acc, prod_p1);
    end

    assign sat_flag = 1'b0;
`endif

    // Band clipped to the last valid bin fft_num>>1; a band starting past it is empty.
    always_comb begin
        half_bins = fft_num_r >> 1;
        avail     = half_bins - band_start_in + BIN_ADDR_WIDTH'(1);
        eff_len   = '0;
        if (band_start_in <= half_bins)
            eff_len = (band_len_in < avail) ? band_len_in : avail;
    end

    assign drain_last = (state == S_DRAIN) && drain_cnt;

    // p0: read data arrives; p1: scaled product registered; then accumulated
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state == S_ACC);
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0)
            prod_p1 <= scale_prod(bin_data_in, coef_in);
        if (state == S_FETCH)
            acc <= '0;
        else
            acc <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mel_num_r      <= '0;
            fft_num_r      <= '0;
            mel_idx        <= '0;
            coef_base      <= '0;
            len_r          <= '0;
            eff_len_r      <= '0;
            k_cnt          <= '0;
            drain_cnt      <= 1'b0;
            band_addr      <= '0;
            bin_read_addr  <= '0;
            coef_read_addr <= '0;
            mel_data_out   <= '0;
            mel_write_addr <= '0;
            write_mel_en   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            write_mel_en <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mel_num_r <= mel_num;
                        fft_num_r <= fft_num;
                        mel_idx   <= '0;
                        coef_base <= '0;
                        busy      <= 1'b1;
                        if (mel_num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            band_addr <= '0;
                        end
                    end
                end
                S_LOAD: state <= S_FETCH;
                S_FETCH: begin
                    len_r     <= band_len_in;
                    eff_len_r <= eff_len;
                    k_cnt     <= '0;
                    if (eff_len == '0) begin
                        // Weight layout follows the unclipped length even for an empty band.
                        coef_base      <= coef_base + COEF_ADDR_WIDTH'(band_len_in);
                        state          <= S_WRITE;
                        write_mel_en   <= 1'b1;
                        mel_data_out   <= '0;
                        mel_write_addr <= mel_idx;
                    end else begin
                        state          <= S_ACC;
                        bin_read_addr  <= band_start_in;
                        coef_read_addr <= coef_base;
                    end
                end
                S_ACC: begin
                    if (k_cnt == eff_len_r - BIN_ADDR_WIDTH'(1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        k_cnt          <= k_cnt + BIN_ADDR_WIDTH'(1);
                        bin_read_addr  <= bin_read_addr + BIN_ADDR_WIDTH'(1);
                        coef_read_addr <= coef_read_addr + COEF_ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                        coef_base <= coef_base + COEF_ADDR_WIDTH'(len_r);
                    end else begin
                        state          <= S_WRITE;
                        write_mel_en   <= 1'b1;
                        mel_data_out   <= acc_next;
                        mel_write_addr <= mel_idx;
                    end
                end
                S_WRITE: begin
                    if (mel_idx == mel_num_r - MEL_WIDTH'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        mel_idx   <= mel_idx + MEL_WIDTH'(1);
                        band_addr <= mel_idx + MEL_WIDTH'(1);
                        state     <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mel_fbank_acc.sv
// Directed bench for mel_fbank_acc: table of single-filter bands plus multi-filter, saturation and reset sequences.
module tb_mel_fbank_acc;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int AW  = 40;
    localparam int BW  = 12;
    localparam int MW  = 6;
    localparam int CAW = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [MW-1:0]  mel_num;
    logic [BW-1:0]  fft_num;
    logic [MW-1:0]  band_addr;
    logic [BW-1:0]  band_start_in;
    logic [BW-1:0]  band_len_in;
    logic [BW-1:0]  bin_read_addr;
    logic [DW-1:0]  bin_data_in;
    logic [CAW-1:0] coef_read_addr;
    logic [CW-1:0]  coef_in;
    logic [AW-1:0]  mel_data_out;
    logic [MW-1:0]  mel_write_addr;
    logic           write_mel_en;
    logic           sat_flag;
    logic           busy;
    logic           done;

    mel_fbank_acc #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW),
        .BIN_ADDR_WIDTH(BW), .MEL_WIDTH(MW), .COEF_ADDR_WIDTH(CAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mel_num(mel_num), .fft_num(fft_num),
        .band_addr(band_addr), .band_start_in(band_start_in), .band_len_in(band_len_in),
        .bin_read_addr(bin_read_addr), .bin_data_in(bin_data_in),
        .coef_read_addr(coef_read_addr), .coef_in(coef_in),
        .mel_data_out(mel_data_out), .mel_write_addr(mel_write_addr),
        .write_mel_en(write_mel_en), .sat_flag(sat_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] pmem   [0:4095];
    logic [CW-1:0] cmem   [0:32767];
    logic [BW-1:0] bstart [0:63];
    logic [BW-1:0] blen   [0:63];

    always @(posedge clk) begin
        bin_data_in   <= pmem[bin_read_addr];
        coef_in       <= cmem[coef_read_addr];
        band_start_in <= bstart[band_addr];
        band_len_in   <= blen[band_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_cyc  [0:255];
    logic [MW-1:0] wr_addr [0:255];
    logic [AW-1:0] wr_data [0:255];
    logic          wr_sat  [0:255];
    int            nwr     = 0;
    int            n_done  = 0;
    int            done_at = 0;

    always @(negedge clk) begin
        if (write_mel_en) begin
            if (nwr < 256) begin
                wr_cyc[nwr]  = cyc;
                wr_addr[nwr] = mel_write_addr;
                wr_data[nwr] = mel_data_out;
                wr_sat[nwr]  = sat_flag;
            end
            nwr = nwr + 1;
        end
        if (done) begin
            done_at = cyc;
            n_done  = n_done + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int t0, nw0, nd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic run_job(input logic [MW-1:0] m, input logic [BW-1:0] f,
                           input int budget, input bit repulse);
        nw0 = nwr;
        nd0 = n_done;
        @(negedge clk);
        mel_num = m; fft_num = f; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < budget && n_done == nd0; i++) begin
            @(negedge clk);
            if (repulse && (cyc - t0 == 3 || cyc - t0 == 5)) begin
                start = 1'b1; mel_num = 7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("job_finished", 64'(n_done > nd0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_wen"}, 64'(write_mel_en), 64'd0);
        chk({tag, "_data"}, 64'(mel_data_out), 64'd0);
        chk({tag, "_waddr"}, 64'(mel_write_addr), 64'd0);
        chk({tag, "_band_addr"}, 64'(band_addr), 64'd0);
        chk({tag, "_bin_addr"}, 64'(bin_read_addr), 64'd0);
        chk({tag, "_coef_addr"}, 64'(coef_read_addr), 64'd0);
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
    endtask

    typedef struct {
        int          st;
        int          len;
        int          fft;
        logic [15:0] coef;
        longint      exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [63:0] p64, s64, exp_sat;
        logic        exp_flag;

        // Bins hold 10*(i-1): bin2=10, bin3=20, ..., bin8=70.
        vecs[0] = '{2, 3, 16, 16'h4000, 30, 8};
        vecs[1] = '{2, 3, 16, 16'h7FFF, 57, 8};
        vecs[2] = '{5, 1, 16, 16'h2000, 10, 6};
        vecs[3] = '{7, 5, 16, 16'h4000, 65, 7};
        vecs[4] = '{9, 4, 16, 16'h4000, 0, 3};
        vecs[5] = '{8, 3, 16, 16'h4000, 35, 6};
        vecs[6] = '{3, 0, 16, 16'h4000, 0, 3};
        vecs[7] = '{3, 2, 16, 16'h6000, 37, 7};
        vecs[8] = '{2, 6, 8, 16'h4000, 30, 8};

        for (int i = 0; i < 4096; i++) pmem[i] = (i == 0) ? 32'd0 : 32'(10 * (i - 1));
        for (int i = 0; i < 32768; i++) cmem[i] = '0;
        for (int i = 0; i < 64; i++) begin bstart[i] = '0; blen[i] = '0; end

        rst = 1'b1; start = 1'b0; mel_num = '0; fft_num = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            bstart[0] = BW'(vecs[v].st);
            blen[0]   = BW'(vecs[v].len);
            for (int c = 0; c < 16; c++) cmem[c] = vecs[v].coef;
            run_job(MW'(1), BW'(vecs[v].fft), 100, 1'b0);
            chk($sformatf("v%0d_writes", v), 64'(nwr - nw0), 64'd1);
            chk($sformatf("v%0d_data", v), 64'(wr_data[nw0]), 64'(vecs[v].exp_data));
            chk($sformatf("v%0d_wcyc", v), 64'(wr_cyc[nw0] - t0), 64'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_waddr", v), 64'(wr_addr[nw0]), 64'd0);
            chk($sformatf("v%0d_sat", v), 64'(wr_sat[nw0]), 64'd0);
            chk($sformatf("v%0d_done", v), 64'(done_at - t0), 64'(vecs[v].exp_cyc + 1));
            chk($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
        end

        // Empty, clipped, then a band whose weights sit at base 5 (unclipped length of filter 1).
        bstart[0] = 0; blen[0] = 0;
        bstart[1] = 7; blen[1] = 5;
        bstart[2] = 3; blen[2] = 2;
        for (int c = 0; c < 5; c++) cmem[c] = 16'h4000;
        cmem[5] = 16'h2000;
        cmem[6] = 16'h6000;
        run_job(MW'(3), BW'(16), 100, 1'b0);
        chk("multi_writes", 64'(nwr - nw0), 64'd3);
        chk("multi_f0_cyc", 64'(wr_cyc[nw0] - t0), 64'd3);
        chk("multi_f0_data", 64'(wr_data[nw0]), 64'd0);
        chk("multi_f0_addr", 64'(wr_addr[nw0]), 64'd0);
        chk("multi_f1_cyc", 64'(wr_cyc[nw0+1] - t0), 64'd10);
        chk("multi_f1_data", 64'(wr_data[nw0+1]), 64'd65);
        chk("multi_f1_addr", 64'(wr_addr[nw0+1]), 64'd1);
        chk("multi_f2_cyc", 64'(wr_cyc[nw0+2] - t0), 64'd17);
        chk("multi_f2_data", 64'(wr_data[nw0+2]), 64'd27);
        chk("multi_f2_addr", 64'(wr_addr[nw0+2]), 64'd2);
        chk("multi_done", 64'(done_at - t0), 64'd18);

        run_job(MW'(0), BW'(16), 20, 1'b0);
        chk("zero_writes", 64'(nwr - nw0), 64'd0);
        chk("zero_done", 64'(done_at - t0), 64'd1);

        bstart[0] = 2; blen[0] = 3;
        for (int c = 0; c < 3; c++) cmem[c] = 16'h4000;
        run_job(MW'(1), BW'(16), 100, 1'b1);
        chk("repulse_writes", 64'(nwr - nw0), 64'd1);
        chk("repulse_data", 64'(wr_data[nw0]), 64'd30);
        chk("repulse_wcyc", 64'(wr_cyc[nw0] - t0), 64'd8);
        chk("repulse_done", 64'(done_at - t0), 64'd9);
        chk("repulse_dones", 64'(n_done - nd0), 64'd1);

        for (int i = 0; i < 600; i++) begin
            pmem[i] = 32'hFFFF_FFFF;
            cmem[i] = 16'h7FFF;
        end
        bstart[0] = 0; blen[0] = 600;
        p64 = (64'hFFFF_FFFF * 64'h7FFF) >> 15;
        s64 = p64 * 64'd600;
`ifdef MEL_ACC_SAT_EN
        exp_sat  = (64'd1 << AW) - 64'd1;
        exp_flag = 1'b1;
`else
        exp_sat  = s64 & ((64'd1 << AW) - 64'd1);
        exp_flag = 1'b0;
`endif
        run_job(MW'(1), BW'(2048), 800, 1'b0);
        chk("sat_writes", 64'(nwr - nw0), 64'd1);
        chk("sat_data", 64'(wr_data[nw0]), exp_sat);
        chk("sat_flag", 64'(wr_sat[nw0]), 64'(exp_flag));
        chk("sat_wcyc", 64'(wr_cyc[nw0] - t0), 64'd605);

        // Abort a long band mid-accumulation.
        nw0 = nwr; nd0 = n_done;
        @(negedge clk);
        mel_num = 1; fft_num = 2048; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("midrst_no_write", 64'(nwr - nw0), 64'd0);
        chk("midrst_no_done", 64'(n_done - nd0), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
